// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// the hardwired zero register index and the bulk-clear FSM states.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reservations,
// cleared by long-latency writeback, with the release visible on the read side.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_all,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              rel_valid,
    input  logic [AW-1:0]     rel_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Reserve is applied after release so a same-cycle pair leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (clr_all) begin
            w_busy_nxt = '0;
        end else begin
            if (rel_valid) w_busy_nxt[rel_addr] = 1'b0;
            if (rsv_valid) w_busy_nxt[rsv_addr] = 1'b1;
        end
        w_busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
        logic [AW-1:0] w_ra;
        logic          w_rel_hit;
        assign w_ra      = rd_addr[k*AW +: AW];
        assign w_rel_hit = rel_valid && (rel_addr == w_ra) &&
                           !(rsv_valid && (rsv_addr == rel_addr));
        assign rd_busy[k] = r_busy[w_ra] && !w_rel_hit;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two write ports, write-to-read
// bypass, pending-write scoreboard and a sequenced bulk-clear engine.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    output clr_state_e          dbg_state
);

    logic [XLEN-1:0] r_regs [NREGS];
    clr_state_e      r_state;
    clr_state_e      w_state_nxt;
    logic [AW-1:0]   r_ptr;

    logic w_idle;
    logic w_we0;
    logic w_we1;
    logic w_rsv;
    logic w_clr_start;
    logic w_last;

    // Every external request is dropped outside IDLE; address 0 never writes or reserves.
    assign w_idle      = (r_state == IDLE);
    assign w_we0       = we0 && w_idle && (wa0 != AW'(ZERO_REG));
    assign w_we1       = we1 && w_idle && (wa1 != AW'(ZERO_REG));
    assign w_rsv       = rsv_valid && w_idle && (rsv_addr != AW'(ZERO_REG));
    assign w_clr_start = clr_req && w_idle;
    assign w_last      = (r_ptr == AW'(NREGS - 1));
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        clr_busy    = 1'b0;
        clr_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_req) w_state_nxt = SWEEP;
            end
            SWEEP: begin
                clr_busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                clr_done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_ptr <= '0;
        else if (w_clr_start)       r_ptr <= AW'(1);
        else if (r_state == SWEEP)  r_ptr <= r_ptr + 1'b1;
    end

    // Entry 0 is only ever reset; reads of it are forced to zero below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if ((r_state == SWEEP) && (r_ptr == AW'(i)))
                    r_regs[i] <= '0;
                else if (w_we1 && (wa1 == AW'(i)))
                    r_regs[i] <= wd1;
                else if (w_we0 && (wa0 == AW'(i)))
                    r_regs[i] <= wd0;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = rd_addr[k*AW +: AW];
        assign rd_data[k*XLEN +: XLEN] =
            (w_ra == AW'(ZERO_REG))    ? '0  :
            (w_we1 && (wa1 == w_ra))   ? wd1 :
            (w_we0 && (wa0 == w_ra))   ? wd0 :
                                         r_regs[w_ra];
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_all   (w_clr_start),
        .rsv_valid (w_rsv),
        .rsv_addr  (rsv_addr),
        .rel_valid (w_we1),
        .rel_addr  (wa1),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );

endmodule
